// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: owns the horizontal/vertical pixel counters, decodes sync,
// blanking and active-area coordinates, and gates scanout with a start/stop FSM.
module vga_timing_ctrl #(
  parameter int unsigned N       = 10,
  parameter int unsigned HSYN    = 96,
  parameter int unsigned HBP     = 48,
  parameter int unsigned HACTIVE = 640,
  parameter int unsigned HFP     = 16,
  parameter int unsigned VSYN    = 2,
  parameter int unsigned VBP     = 33,
  parameter int unsigned VACTIVE = 480,
  parameter int unsigned VFP     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_en,
  input  logic         en,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic         frame_start,
  output logic         line_end,
  output logic         busy
);

  localparam int unsigned HMAX = HSYN + HBP + HACTIVE + HFP;
  localparam int unsigned VMAX = VSYN + VBP + VACTIVE + VFP;
  localparam int unsigned CW   = N + 1;

  // Region bounds carry one extra bit so an end bound equal to 2^N still compares correctly.
  localparam logic [N:0]   H_SYN_END = CW'(HSYN);
  localparam logic [N:0]   H_ACT_BEG = CW'(HSYN + HBP);
  localparam logic [N:0]   H_ACT_END = CW'(HSYN + HBP + HACTIVE);
  localparam logic [N:0]   V_SYN_END = CW'(VSYN);
  localparam logic [N:0]   V_ACT_BEG = CW'(VSYN + VBP);
  localparam logic [N:0]   V_ACT_END = CW'(VSYN + VBP + VACTIVE);
  localparam logic [N-1:0] H_OFS     = N'(HSYN + HBP);
  localparam logic [N-1:0] V_OFS     = N'(VSYN + VBP);
  localparam logic [N-1:0] H_LAST    = N'(HMAX - 1);
  localparam logic [N-1:0] V_LAST    = N'(VMAX - 1);

  if ((64'(HMAX) > (64'd1 << N)) || (64'(VMAX) > (64'd1 << N))) begin : g_cfg_err
    $error("vga_timing_ctrl: HMAX or VMAX exceeds 2^N");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] hcount_q, hcount_d;
  logic [N-1:0] vcount_q, vcount_d;

  logic         tick;
  logic         h_last;
  logic         v_last;
  logic [N:0]   h_ext;
  logic [N:0]   v_ext;
  logic         h_act;
  logic         v_act;

  assign tick   = pix_en && (state_q != ST_IDLE);
  assign h_last = (hcount_q == H_LAST);
  assign v_last = (vcount_q == V_LAST);
  assign h_ext  = {1'b0, hcount_q};
  assign v_ext  = {1'b0, vcount_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // Raster advance and start/stop sequencing; stopping is only honoured at end of frame.
  always_comb begin
    state_d  = state_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? '0 : vcount_q + N'(1);
      end else begin
        hcount_d = hcount_q + N'(1);
      end
    end
    case (state_q)
      ST_IDLE: begin
        hcount_d = '0;
        vcount_d = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en)                            state_d = ST_RUN;
        else if (tick && h_last && v_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode straight from the registers; IDLE presents the reset values.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    hsync       = 1'b1;
    vsync       = 1'b1;
    h_act       = 1'b0;
    v_act       = 1'b0;
    video_on    = 1'b0;
    x           = '0;
    y           = '0;
    frame_start = 1'b0;
    line_end    = 1'b0;
    if (busy) begin
      hsync       = !(h_ext < H_SYN_END);
      vsync       = !(v_ext < V_SYN_END);
      h_act       = (h_ext >= H_ACT_BEG) && (h_ext < H_ACT_END);
      v_act       = (v_ext >= V_ACT_BEG) && (v_ext < V_ACT_END);
      video_on    = h_act && v_act;
      frame_start = pix_en && (hcount_q == '0) && (vcount_q == '0);
      line_end    = pix_en && h_last;
      if (video_on) begin
        x = hcount_q - H_OFS;
        y = vcount_q - V_OFS;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a small raster and the default 640x480 raster share
// stimulus and are checked each cycle against a frame-position model.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  logic en;
  logic half;
  logic pe_level;

  always #5 clk = ~clk;

  logic       s_hs, s_vs, s_von, s_fs, s_le, s_busy;
  logic [3:0] s_x, s_y;
  logic       b_hs, b_vs, b_von, b_fs, b_le, b_busy;
  logic [9:0] b_x, b_y;

  vga_timing_ctrl #(
    .N(4), .HSYN(2), .HBP(1), .HACTIVE(4), .HFP(1),
    .VSYN(1), .VBP(1), .VACTIVE(2), .VFP(1)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .en(en),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .x(s_x), .y(s_y),
    .frame_start(s_fs), .line_end(s_le), .busy(s_busy)
  );

  vga_timing_ctrl dut_big (
    .clk(clk), .rst(rst), .pix_en(pix_en), .en(en),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .x(b_x), .y(b_y),
    .frame_start(b_fs), .line_end(b_le), .busy(b_busy)
  );

  int c_hsyn[2] = '{2, 96};
  int c_hbp[2]  = '{1, 48};
  int c_hact[2] = '{4, 640};
  int c_hfp[2]  = '{1, 16};
  int c_vsyn[2] = '{1, 2};
  int c_vbp[2]  = '{1, 33};
  int c_vact[2] = '{2, 480};
  int c_vfp[2]  = '{1, 10};

  // Model: 0 = stopped, 1 = running, 2 = running with a stop pending; pos = ticks into frame
  int m_mode[2] = '{0, 0};
  int m_pos[2]  = '{0, 0};

  int n_checks = 0;
  int n_err    = 0;

  function automatic int hmax(input int k);
    return c_hsyn[k] + c_hbp[k] + c_hact[k] + c_hfp[k];
  endfunction

  function automatic int vmax(input int k);
    return c_vsyn[k] + c_vbp[k] + c_vact[k] + c_vfp[k];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : model
    int fr;
    bit eof;
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_mode[k] = 0;
          m_pos[k]  = 0;
        end else if (m_mode[k] == 0) begin
          if (en) begin
            m_mode[k] = 1;
            m_pos[k]  = 0;
          end
        end else begin
          fr  = hmax(k) * vmax(k);
          eof = pix_en && (m_pos[k] == fr - 1);
          if (pix_en) m_pos[k] = (m_pos[k] + 1) % fr;
          if (m_mode[k] == 1) begin
            if (!en) m_mode[k] = 2;
          end else if (en) begin
            m_mode[k] = 1;
          end else if (eof) begin
            m_mode[k] = 0;
            m_pos[k]  = 0;
          end
        end
      end
    end
  end

  initial begin : compare
    int h, v, hofs, vofs;
    logic e_hs, e_vs, e_von, e_fs, e_le, e_busy;
    int e_x, e_y;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        h      = m_pos[k] % hmax(k);
        v      = m_pos[k] / hmax(k);
        hofs   = c_hsyn[k] + c_hbp[k];
        vofs   = c_vsyn[k] + c_vbp[k];
        e_busy = (m_mode[k] != 0);
        e_hs   = !(e_busy && h < c_hsyn[k]);
        e_vs   = !(e_busy && v < c_vsyn[k]);
        e_von  = e_busy && h >= hofs && h < hofs + c_hact[k] && v >= vofs && v < vofs + c_vact[k];
        e_x    = e_von ? h - hofs : 0;
        e_y    = e_von ? v - vofs : 0;
        e_fs   = e_busy && pix_en && m_pos[k] == 0;
        e_le   = e_busy && pix_en && h == hmax(k) - 1;
        if (k == 0) begin
          chk("s.hsync", 32'(s_hs), 32'(e_hs));
          chk("s.vsync", 32'(s_vs), 32'(e_vs));
          chk("s.video_on", 32'(s_von), 32'(e_von));
          chk("s.x", 32'(s_x), 32'(e_x));
          chk("s.y", 32'(s_y), 32'(e_y));
          chk("s.frame_start", 32'(s_fs), 32'(e_fs));
          chk("s.line_end", 32'(s_le), 32'(e_le));
          chk("s.busy", 32'(s_busy), 32'(e_busy));
        end else begin
          chk("b.hsync", 32'(b_hs), 32'(e_hs));
          chk("b.vsync", 32'(b_vs), 32'(e_vs));
          chk("b.video_on", 32'(b_von), 32'(e_von));
          chk("b.x", 32'(b_x), 32'(e_x));
          chk("b.y", 32'(b_y), 32'(e_y));
          chk("b.frame_start", 32'(b_fs), 32'(e_fs));
          chk("b.line_end", 32'(b_le), 32'(e_le));
          chk("b.busy", 32'(b_busy), 32'(e_busy));
        end
      end
    end
  end

  initial begin : pix_drv
    pix_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_en = half ? !pix_en : pe_level;
    end
  end

  // Wait (bounded) until the model shows raster position (h,v) on config k
  task automatic goto(input int k, input int h, input int v, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_mode[k] != 0 && m_pos[k] == v * hmax(k) + h) begin
        found = 1'b1;
        break;
      end
    end
    chk($sformatf("reach(%0d,%0d,%0d)", k, h, v), 32'(found), 32'd1);
  endtask

  function automatic logic pulse(input int sel);
    return (sel == 0) ? s_fs : s_le;
  endfunction

  // Spacing in clocks between consecutive pulses of frame_start (sel 0) or line_end (sel 1)
  task automatic measure(input int sel, output int per);
    int i;
    per = -1;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pulse(sel)) break;
    end
    if (i < 300) begin
      for (int j = 1; j <= 300; j++) begin
        @(negedge clk);
        if (pulse(sel)) begin
          per = j;
          break;
        end
      end
    end
  endtask

  initial begin : timeout
    #1_000_000;
    $display("FAIL timeout: bench did not complete, errors so far %0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin : main
    int per;
    bit found;
    rst      = 1'b1;
    en       = 1'b0;
    half     = 1'b0;
    pe_level = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.hsync", 32'(s_hs), 32'd1);
    chk("rst.vsync", 32'(s_vs), 32'd1);
    chk("rst.busy", 32'(s_busy), 32'd0);
    chk("rst.video_on", 32'(s_von), 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first.frame_start", 32'(s_fs), 32'd1);
    chk("first.hsync", 32'(s_hs), 32'd0);
    chk("first.vsync", 32'(s_vs), 32'd0);
    chk("first.busy", 32'(s_busy), 32'd1);

    goto(0, 6, 3, 100);
    chk("p63.video_on", 32'(s_von), 32'd1);
    chk("p63.x", 32'(s_x), 32'd3);
    chk("p63.y", 32'(s_y), 32'd1);
    goto(0, 7, 2, 100);
    chk("p72.line_end", 32'(s_le), 32'd1);
    chk("p72.video_on", 32'(s_von), 32'd0);
    chk("p72.hsync", 32'(s_hs), 32'd1);

    measure(0, per);
    chk("full.frame_period", 32'(per), 32'd40);
    measure(1, per);
    chk("full.line_period", 32'(per), 32'd8);

    @(posedge clk); #1;
    half = 1'b1;
    measure(0, per);
    measure(0, per);
    chk("half.frame_period", 32'(per), 32'd80);
    measure(1, per);
    chk("half.line_period", 32'(per), 32'd16);
    @(posedge clk); #1;
    half = 1'b0;

    goto(0, 5, 2, 200);
    @(posedge clk); #1;
    en = 1'b0;
    goto(0, 7, 4, 200);
    chk("drain.busy_at_end", 32'(s_busy), 32'd1);
    @(negedge clk);
    chk("drain.idle_busy", 32'(s_busy), 32'd0);
    chk("drain.idle_hsync", 32'(s_hs), 32'd1);
    chk("drain.idle_vsync", 32'(s_vs), 32'd1);
    repeat (5) @(negedge clk);
    chk("drain.still_idle", 32'(s_busy), 32'd0);

    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    goto(0, 2, 3, 200);
    @(posedge clk); #1;
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_fs) begin
        found = 1'b1;
        break;
      end
    end
    chk("reassert.frame_start_seen", 32'(found), 32'd1);
    chk("reassert.busy", 32'(s_busy), 32'd1);

    goto(0, 4, 3, 200);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst.hsync", 32'(s_hs), 32'd1);
    chk("midrst.vsync", 32'(s_vs), 32'd1);
    chk("midrst.video_on", 32'(s_von), 32'd0);
    chk("midrst.x", 32'(s_x), 32'd0);
    chk("midrst.y", 32'(s_y), 32'd0);
    chk("midrst.frame_start", 32'(s_fs), 32'd0);
    chk("midrst.line_end", 32'(s_le), 32'd0);
    chk("midrst.busy", 32'(s_busy), 32'd0);
    chk("midrst.big_busy", 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("after_rst.frame_start", 32'(s_fs), 32'd1);
    chk("after_rst.hsync", 32'(s_hs), 32'd0);
    chk("after_rst.big_frame_start", 32'(b_fs), 32'd1);

    goto(1, 144, 35, 40000);
    chk("big.first_active", 32'(b_von), 32'd1);
    chk("big.x0", 32'(b_x), 32'd0);
    chk("big.y0", 32'(b_y), 32'd0);
    goto(1, 783, 35, 1000);
    chk("big.x639", 32'(b_x), 32'd639);
    chk("big.von_783", 32'(b_von), 32'd1);
    @(negedge clk);
    chk("big.von_784", 32'(b_von), 32'd0);
    chk("big.x_784", 32'(b_x), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the VGA raster by owning the horizontal and vertical pixel counters.
- Compares the counters against the sync, back-porch, active and front-porch boundaries to produce hsync, vsync, the blanking signals and the pixel coordinates for the framebuffer reader.
- Adds a start/stop FSM so scanout always begins at the frame origin and only stops on a frame boundary.
- Sits between the pixel-clock enable generator and the framebuffer/colour output stage of the VGA controller.

Parameters:
- N, 10, counter and coordinate width in bits.
- HSYN, 96, horizontal sync width in pixels.
- HBP, 48, horizontal back porch in pixels.
- HACTIVE, 640, horizontal visible pixels.
- HFP, 16, horizontal front porch in pixels.
- VSYN, 2, vertical sync width in lines.
- VBP, 33, vertical back porch in lines.
- VACTIVE, 480, vertical visible lines.
- VFP, 10, vertical front porch in lines.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- pix_en  input  1  pixel tick; counters advance only on clk edges where pix_en=1
- en  input  1  scanout enable request
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- video_on  output  1  high in the active region of both axes
- x  output  N  pixel column within the active region; 0 when not video_on
- y  output  N  pixel row within the active region; 0 when not video_on
- frame_start  output  1  one-clk pulse at the first pixel tick of each frame
- line_end  output  1  one-clk pulse at the last pixel tick of each line
- busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Derived constants:
  - HMAX = HSYN+HBP+HACTIVE+HFP; VMAX = VSYN+VBP+VACTIVE+VFP.
  - Both must be at most 2^N; this is checked at elaboration.
- Region order per axis, with counter c running from 0:
  - SYNC: [0, SYN)
  - BP: [SYN, SYN+BP)
  - ACTIVE: [SYN+BP, SYN+BP+ACTIVE)
  - FP: up to MAX-1
- Registers: hcount and vcount (N bits each) and a 2-bit state. All outputs decode combinationally from these registers, so there is no latency relative to the counters.
- Reset (async): hcount=0, vcount=0, state=IDLE. Outputs: hsync=1, vsync=1, video_on=0, x=0, y=0, frame_start=0, line_end=0, busy=0.
- Counting, only when state is RUN or DRAIN and pix_en=1:
  - If hcount==HMAX-1: hcount<=0, then vcount<=0 if vcount==VMAX-1, else vcount+1.
  - Otherwise hcount<=hcount+1.
  - When pix_en=0, the counters hold.
- Decode, valid only in RUN or DRAIN:
  - hsync = !(hcount<HSYN).
  - vsync = !(vcount<VSYN).
  - video_on = hcount in H ACTIVE and vcount in V ACTIVE.
  - x = hcount-(HSYN+HBP), y = vcount-(VSYN+VBP), each forced to 0 when video_on=0.
  - In IDLE, all decodes are held at their reset values.
- frame_start = pix_en & (state!=IDLE) & hcount==0 & vcount==0.
- line_end = pix_en & (state!=IDLE) & hcount==HMAX-1.
- FSM:
  - IDLE: counters held at 0. en=1 -> RUN on the next clk edge, regardless of pix_en. The first pix_en tick in RUN is pixel (0,0) and raises frame_start.
  - RUN: en=0 -> DRAIN. Counting continues uninterrupted.
  - DRAIN:
    - Counting continues.
    - en=1 -> RUN with the counters undisturbed.
    - On the end-of-frame tick (pix_en, hcount=HMAX-1, vcount=VMAX-1) with en=0 -> IDLE, counters wrap to 0.
    - If en=1 on that same tick, RUN wins and the counters wrap normally.
- busy = (state!=IDLE).
- Reset mid-frame: all registers return to 0/IDLE immediately (asynchronously); no partial frame resumes.

Test Plan:
- Small config (HSYN=2, HBP=1, HACTIVE=4, HFP=1, VSYN=1, VBP=1, VACTIVE=2, VFP=1; HMAX=8, VMAX=5), pix_en=1 continuously, en=1:
  - hsync=0 for hcount 0..1.
  - video_on=1 for hcount 3..6 on vcount 2..3, with x=0..3 and y=0..1.
  - line_end every 8 clks; frame_start every 40 clks.
- Same config, pix_en high one clk in two: every counter value persists 2 clks, frame period 80 clks, frame_start and line_end remain single-clk pulses.
- Drop en at hcount=5, vcount=2:
  - busy stays 1 and scanout continues through (7,4).
  - IDLE is entered on the next edge; hsync=vsync=1 and busy=0 thereafter.
- Drop en, then reassert it at (2,3) during DRAIN: state returns to RUN, no counter discontinuity, and frame_start occurs at the normal wrap.
- Assert rst at (4,3): all outputs take their reset values within the same clk. After rst release with en=1, the first pix_en tick shows hcount=0, vcount=0 and frame_start=1.
- Default 640x480 config: HMAX=800, VMAX=525. frame_start is spaced 420000 pixel ticks apart, and x reaches 639 at hcount=783 while y reaches 479 at vcount=514.
